// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if
// Bundle of operation request, MTHI/MTLO write, status and HI/LO signals
// between the datapath (master) and the multiply/divide unit (slave).
//   i_start, i_op            : operation request; op 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   i_operand_a, i_operand_b : rs/rt operands (multiplicand/dividend, multiplier/divisor)
//   i_hi_write, i_lo_write   : MTHI / MTLO strobes
//   i_write_data             : MTHI / MTLO data
//   o_busy, o_done           : operation in flight, one-cycle completion pulse
//   o_div_by_zero            : completed divide had a zero divisor
//   o_hi, o_lo               : architectural HI / LO registers
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             i_start;
    logic [1:0]       i_op;
    logic [WIDTH-1:0] i_operand_a;
    logic [WIDTH-1:0] i_operand_b;
    logic             i_hi_write;
    logic             i_lo_write;
    logic [WIDTH-1:0] i_write_data;
    logic             o_busy;
    logic             o_done;
    logic             o_div_by_zero;
    logic [WIDTH-1:0] o_hi;
    logic [WIDTH-1:0] o_lo;

    modport master (
        output i_start, i_op, i_operand_a, i_operand_b,
        output i_hi_write, i_lo_write, i_write_data,
        input  o_busy, o_done, o_div_by_zero, o_hi, o_lo
    );

    modport slave (
        input  i_start, i_op, i_operand_a, i_operand_b,
        input  i_hi_write, i_lo_write, i_write_data,
        output o_busy, o_done, o_div_by_zero, o_hi, o_lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit
// Iterative radix-2 multiply/divide unit holding the MIPS HI/LO registers.
// An accepted operation works on operand magnitudes for 32 steps, applies the
// sign correction in a final cycle and writes HI/LO 33 cycles after start.
//   clk   : rising-edge clock
//   reset : synchronous, active-high reset
//   bus   : slave side of mult_div_unit_if (request, MTHI/MTLO, status, HI/LO)
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           reset,
    mult_div_unit_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIN
    } state_t;

    state_t             r_state;
    state_t             w_nextState;
    logic [4:0]         r_count;
    logic               r_isDiv;
    logic               r_negResult;
    logic               r_negRem;
    logic               r_zeroDivisor;
    logic [WIDTH-1:0]   r_origA;
    logic [WIDTH-1:0]   r_operand;
    logic [2*WIDTH-1:0] r_accum;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;
    logic               r_divByZero;

    logic               w_signedOp;
    logic               w_negA;
    logic               w_negB;
    logic [WIDTH-1:0]   w_absA;
    logic [WIDTH-1:0]   w_absB;
    logic [WIDTH-1:0]   w_addend;
    logic [WIDTH:0]     w_mulSum;
    logic [2*WIDTH-1:0] w_mulStep;
    logic [WIDTH-1:0]   w_remShift;
    logic               w_divFits;
    logic [2*WIDTH-1:0] w_divStep;
    logic [2*WIDTH-1:0] w_product;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: 32 CALC steps, then a single FIN cycle
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (bus.i_start) w_nextState = CALC;
            CALC:    if (r_count == 5'd31) w_nextState = FIN;
            FIN:     w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Operand magnitudes; unsigned ops (op[0]=1) pass raw values through
    always_comb begin
        w_signedOp = ~bus.i_op[0];
        w_negA     = w_signedOp & bus.i_operand_a[WIDTH-1];
        w_negB     = w_signedOp & bus.i_operand_b[WIDTH-1];
        w_absA     = w_negA ? (~bus.i_operand_a + 1'b1) : bus.i_operand_a;
        w_absB     = w_negB ? (~bus.i_operand_b + 1'b1) : bus.i_operand_b;
    end

    // Iteration steps. Multiply: accumulator starts as {0, multiplier}; each
    // step conditionally adds the multiplicand to the upper half and shifts
    // right. Divide: accumulator starts as {0, dividend}; each step shifts the
    // remainder left, trial-subtracts the divisor and shifts in the quotient
    // bit. The remainder's top bit being shifted out means the trial always
    // fits, which keeps the compare and subtract at WIDTH bits.
    always_comb begin
        w_addend   = r_accum[0] ? r_operand : '0;
        w_mulSum   = {1'b0, r_accum[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
        w_mulStep  = {w_mulSum, r_accum[WIDTH-1:1]};
        w_remShift = {r_accum[2*WIDTH-2:WIDTH], r_accum[WIDTH-1]};
        w_divFits  = r_accum[2*WIDTH-1] | (w_remShift >= r_operand);
        w_divStep  = {(w_divFits ? (w_remShift - r_operand) : w_remShift),
                      r_accum[WIDTH-2:0], w_divFits};
    end

    // Sign correction applied in FIN
    always_comb begin
        w_product = r_negResult ? (~r_accum + 1'b1) : r_accum;
        w_quot    = r_negResult ? (~r_accum[WIDTH-1:0] + 1'b1) : r_accum[WIDTH-1:0];
        w_rem     = r_negRem ? (~r_accum[2*WIDTH-1:WIDTH] + 1'b1)
                             : r_accum[2*WIDTH-1:WIDTH];
    end

    // Datapath and architectural registers. MTHI/MTLO only land in IDLE; when
    // they coincide with a start the later FIN write overwrites them.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count       <= '0;
            r_isDiv       <= 1'b0;
            r_negResult   <= 1'b0;
            r_negRem      <= 1'b0;
            r_zeroDivisor <= 1'b0;
            r_origA       <= '0;
            r_operand     <= '0;
            r_accum       <= '0;
            r_hi          <= '0;
            r_lo          <= '0;
            r_done        <= 1'b0;
            r_divByZero   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.i_hi_write) r_hi <= bus.i_write_data;
                    if (bus.i_lo_write) r_lo <= bus.i_write_data;
                    if (bus.i_start) begin
                        r_count       <= '0;
                        r_isDiv       <= bus.i_op[1];
                        r_negResult   <= w_negA ^ w_negB;
                        r_negRem      <= w_negA;
                        r_zeroDivisor <= bus.i_op[1] && (bus.i_operand_b == '0);
                        r_origA       <= bus.i_operand_a;
                        r_divByZero   <= 1'b0;
                        if (bus.i_op[1]) begin
                            r_operand <= w_absB;
                            r_accum   <= {{WIDTH{1'b0}}, w_absA};
                        end else begin
                            r_operand <= w_absA;
                            r_accum   <= {{WIDTH{1'b0}}, w_absB};
                        end
                    end
                end
                CALC: begin
                    r_count <= r_count + 5'd1;
                    r_accum <= r_isDiv ? w_divStep : w_mulStep;
                end
                FIN: begin
                    r_done      <= 1'b1;
                    r_divByZero <= r_zeroDivisor;
                    if (!r_isDiv) begin
                        r_hi <= w_product[2*WIDTH-1:WIDTH];
                        r_lo <= w_product[WIDTH-1:0];
                    end else if (r_zeroDivisor) begin
                        r_hi <= r_origA;
                        r_lo <= '1;
                    end else begin
                        r_hi <= w_rem;
                        r_lo <= w_quot;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.o_busy        = (r_state != IDLE);
    assign bus.o_done        = r_done;
    assign bus.o_div_by_zero = r_divByZero;
    assign bus.o_hi          = r_hi;
    assign bus.o_lo          = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit
// Self-checking bench for mult_div_unit: directed cases plus randomized
// operations compared against an arithmetic reference model.
module tb_mult_div_unit;

    localparam int WIDTH = 32;

    logic clk = 1'b0;
    logic reset;
    int   checkCount = 0;
    int   errorCount = 0;

    mult_div_unit_if #(.WIDTH(WIDTH)) bus ();

    mult_div_unit #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference model from the architectural rules using 64-bit arithmetic
    function automatic void refModel(input logic [1:0] op, input logic [31:0] a,
                                     input logic [31:0] b, output logic [31:0] hi,
                                     output logic [31:0] lo, output logic dz);
        longint          sa, sb, q, r;
        longint unsigned ua, ub, p, uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        hi = '0;
        lo = '0;
        dz = 1'b0;
        if (op == 2'b00) begin
            q = sa * sb;
            {hi, lo} = q;
        end else if (op == 2'b01) begin
            p = ua * ub;
            {hi, lo} = p;
        end else if (b == 32'd0) begin
            hi = a;
            lo = 32'hFFFFFFFF;
            dz = 1'b1;
        end else if (op == 2'b10) begin
            q  = sa / sb;
            r  = sa % sb;
            hi = r[31:0];
            lo = q[31:0];
        end else begin
            uq = ua / ub;
            ur = ua % ub;
            hi = ur[31:0];
            lo = uq[31:0];
        end
    endfunction

    // IDLE write of HI and/or LO, checked on the following cycle
    task automatic writeHiLo(input logic hiW, input logic loW, input logic [31:0] data);
        @(negedge clk);
        bus.i_hi_write   = hiW;
        bus.i_lo_write   = loW;
        bus.i_write_data = data;
        @(posedge clk);
        #1;
        bus.i_hi_write = 1'b0;
        bus.i_lo_write = 1'b0;
        if (hiW) checkOutput("mthi", 64'(bus.o_hi), 64'(data));
        if (loW) checkOutput("mtlo", 64'(bus.o_lo), 64'(data));
    endtask

    // Wait for done, bounded; returns cycles since the last sampled edge
    task automatic waitDone(output int cycles, output int busyDrops);
        cycles    = 0;
        busyDrops = 0;
        while (!bus.o_done && cycles < 40) begin
            @(posedge clk);
            #1;
            cycles++;
            if (!bus.o_done && !bus.o_busy) busyDrops++;
        end
    endtask

    // One operation: start pulse, operands scrambled after acceptance,
    // latency/busy/result/flag checks and done-pulse width check
    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input string tag);
        logic [31:0] expHi, expLo;
        logic        expDz;
        int          cycles, busyDrops;
        refModel(op, a, b, expHi, expLo, expDz);
        @(negedge clk);
        bus.i_start     = 1'b1;
        bus.i_op        = op;
        bus.i_operand_a = a;
        bus.i_operand_b = b;
        @(posedge clk);
        #1;
        bus.i_start     = 1'b0;
        bus.i_op        = 2'($urandom);
        bus.i_operand_a = $urandom;
        bus.i_operand_b = $urandom;
        checkOutput({tag, " busy"}, 64'(bus.o_busy), 64'd1);
        waitDone(cycles, busyDrops);
        checkOutput({tag, " latency"}, 64'(cycles), 64'd33);
        checkOutput({tag, " busyDrops"}, 64'(busyDrops), 64'd0);
        checkOutput({tag, " busyOff"}, 64'(bus.o_busy), 64'd0);
        checkOutput({tag, " hiLo"}, {bus.o_hi, bus.o_lo}, {expHi, expLo});
        checkOutput({tag, " dz"}, 64'(bus.o_div_by_zero), 64'(expDz));
        @(posedge clk);
        #1;
        checkOutput({tag, " donePulse"}, 64'(bus.o_done), 64'd0);
    endtask

    initial begin
        int          cycles, busyDrops, doneCount;
        logic [1:0]  rop;
        logic [31:0] ra, rb;

        reset            = 1'b1;
        bus.i_start      = 1'b0;
        bus.i_op         = 2'b00;
        bus.i_operand_a  = '0;
        bus.i_operand_b  = '0;
        bus.i_hi_write   = 1'b0;
        bus.i_lo_write   = 1'b0;
        bus.i_write_data = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset hiLo", {bus.o_hi, bus.o_lo}, 64'd0);
        checkOutput("reset status", {61'd0, bus.o_busy, bus.o_done, bus.o_div_by_zero}, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Directed arithmetic cases
        applyStimulus(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, "multuMax");
        checkOutput("multuMax exact", {bus.o_hi, bus.o_lo}, 64'hFFFFFFFE_00000001);
        applyStimulus(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, "multNeg1");
        checkOutput("multNeg1 exact", {bus.o_hi, bus.o_lo}, 64'h00000000_00000001);
        applyStimulus(2'b00, 32'h00000007, 32'hFFFFFFFD, "multMixed");
        checkOutput("multMixed exact", {bus.o_hi, bus.o_lo}, 64'hFFFFFFFF_FFFFFFEB);
        applyStimulus(2'b10, 32'hFFFFFFF9, 32'h00000002, "divNeg");
        checkOutput("divNeg exact", {bus.o_hi, bus.o_lo}, 64'hFFFFFFFF_FFFFFFFD);
        applyStimulus(2'b11, 32'd100, 32'd7, "divu");
        checkOutput("divu exact", {bus.o_hi, bus.o_lo}, {32'd2, 32'd14});
        applyStimulus(2'b10, 32'h80000000, 32'hFFFFFFFF, "divOvf");
        checkOutput("divOvf exact", {bus.o_hi, bus.o_lo}, 64'h00000000_80000000);
        applyStimulus(2'b11, 32'h12345678, 32'd0, "divuZero");
        checkOutput("divuZero exact", {bus.o_hi, bus.o_lo}, 64'h12345678_FFFFFFFF);
        checkOutput("divuZero flagHeld", 64'(bus.o_div_by_zero), 64'd1);
        applyStimulus(2'b10, 32'h80000005, 32'd0, "divZeroSigned");

        // Start held high with operand changes and an ignored MTHI in CALC
        writeHiLo(1'b1, 1'b1, 32'h11111111);
        @(negedge clk);
        bus.i_start     = 1'b1;
        bus.i_op        = 2'b01;
        bus.i_operand_a = 32'd3;
        bus.i_operand_b = 32'd5;
        @(posedge clk);
        #1;
        cycles = 0;
        while (!bus.o_done && cycles < 40) begin
            if (cycles == 5) begin
                bus.i_op        = 2'b11;
                bus.i_operand_a = 32'd100;
                bus.i_operand_b = 32'd7;
            end
            if (cycles == 10) begin
                bus.i_hi_write   = 1'b1;
                bus.i_write_data = 32'hDEADBEEF;
            end
            if (cycles == 11) begin
                bus.i_hi_write = 1'b0;
                checkOutput("calc mthi ignored", 64'(bus.o_hi), 64'h11111111);
            end
            @(posedge clk);
            #1;
            cycles++;
        end
        checkOutput("held latency", 64'(cycles), 64'd33);
        checkOutput("held first result", {bus.o_hi, bus.o_lo}, {32'd0, 32'd15});
        @(posedge clk);
        #1;
        checkOutput("held reaccept", 64'(bus.o_busy), 64'd1);
        bus.i_start = 1'b0;
        waitDone(cycles, busyDrops);
        checkOutput("held second latency", 64'(cycles), 64'd33);
        checkOutput("held second result", {bus.o_hi, bus.o_lo}, {32'd2, 32'd14});

        // Reset mid-operation discards the operation
        writeHiLo(1'b1, 1'b0, 32'hA5A5A5A5);
        @(negedge clk);
        bus.i_start     = 1'b1;
        bus.i_op        = 2'b01;
        bus.i_operand_a = 32'h00001234;
        bus.i_operand_b = 32'h00005678;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midReset hiLo", {bus.o_hi, bus.o_lo}, 64'd0);
        checkOutput("midReset busy", 64'(bus.o_busy), 64'd0);
        @(negedge clk);
        reset     = 1'b0;
        doneCount = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.o_done) doneCount++;
        end
        checkOutput("midReset noDone", 64'(doneCount), 64'd0);

        // Randomized operations against the reference model
        for (int i = 0; i < 24; i++) begin
            rop = 2'($urandom);
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 15));
                2: rb = 32'hFFFFFFFF;
                3: ra = 32'h80000000;
                default: ;
            endcase
            applyStimulus(rop, ra, rb, "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multiply/divide unit with architectural HI/LO registers for the MIPS datapath. It sits directly downstream of the register file and takes rs/rt operands (read_data_1/read_data_2) for MULT, MULTU, DIV and DIVU. It produces a 64-bit result in HI/LO after a fixed 33-cycle latency and exposes HI/LO for MFHI/MFLO. It also accepts direct MTHI/MTLO writes.

## Interface
- WIDTH, 32, operand and HI/LO width; only 32 is supported.
- clk  input  1  rising-edge clock; all state changes on posedge clk.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a new operation; sampled only in IDLE.
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start.
- operand_a  input  WIDTH  rs value (multiplicand or dividend).
- operand_b  input  WIDTH  rt value (multiplier or divisor).
- hi_write  input  1  MTHI: HI <= write_data (IDLE only).
- lo_write  input  1  MTLO: LO <= write_data (IDLE only).
- write_data  input  WIDTH  data for MTHI/MTLO.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse: HI/LO were just updated by an operation.
- div_by_zero  output  1  valid with done; 1 if the completed DIV/DIVU had operand_b == 0.
- hi  output  WIDTH  HI register (remainder / upper product).
- lo  output  WIDTH  LO register (quotient / lower product).

## Operation
- States: IDLE, CALC, FIN. A 5-bit iteration counter runs in CALC.
- **IDLE**:
  - If start=1 at an edge: latch op; latch |a| and |b| (magnitudes for signed ops, raw values for unsigned); record the result signs; clear the counter; go to CALC; busy<=1.
  - If hi_write or lo_write is set at the same edge, it still takes effect.
- **CALC**: one radix-2 step per edge; counter increments each step.
  - Multiply: shift-add over a 64-bit accumulator.
  - Divide: restoring division (shift remainder left, trial subtract, set quotient bit).
  - When the counter == 31 step completes, go to FIN.
- **FIN**, one edge:
  - Apply sign correction and write HI/LO.
  - done<=1, busy<=0, and go to IDLE.
- **Sign rules**:
  - MULT: negate the 64-bit product if the operand signs differ.
  - DIV: quotient is negated if the signs differ, truncating toward zero; remainder takes the sign of the dividend.
  - Unsigned ops: no correction.
- **Divide by zero** (operand_b == 0 on DIV/DIVU):
  - Full latency still applies.
  - HI = original operand_a, LO = 32'hFFFFFFFF.
  - div_by_zero=1 together with done.
- **Overflow**: DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0, with no flag.
- **Ignored inputs**:
  - start in CALC or FIN is ignored; it is not queued.
  - hi_write/lo_write in CALC or FIN are ignored.
  - Operand and op changes after acceptance have no effect.
- MTHI/MTLO ordering: if both hi_write and start are set in IDLE, the write lands first; the operation result later overwrites HI/LO.

## Timing
- Start accepted at edge E0: busy=1 after E0.
- CALC steps occur at edges E1..E32.
- FIN at E33: HI/LO carry the new result after E33; busy=0 and done=1 for the cycle after E33 only.
- Latency from start edge to result is 33 cycles.
- Next start is accepted at E34 at the earliest. A start held continuously is therefore re-accepted at E34.
- hi/lo are registered outputs and change only at reset, FIN, or IDLE MTHI/MTLO edges.
- div_by_zero is held from FIN until the next accepted start or reset.
- **Reset** (at any edge, including mid-CALC/FIN):
  - state=IDLE, counter=0.
  - busy=0, done=0, div_by_zero=0, hi=0, lo=0.
  - Any in-flight operation is discarded and no done pulse is produced.
- done never asserts without a preceding accepted start.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF, start at E0 -> busy E0–E32, done one cycle after E33, HI=0xFFFFFFFE, LO=0x00000001.
- MULT 0xFFFFFFFF × 0xFFFFFFFF -> HI=0, LO=1; MULT 0x00000007 × 0xFFFFFFFD -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- DIV 0xFFFFFFF9 (−7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 100 / 7 -> LO=14, HI=2; DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU 0x12345678 / 0 -> HI=0x12345678, LO=0xFFFFFFFF, div_by_zero=1 with done.
- Start held high for 40 cycles with operand changes mid-operation -> first result uses E0 operands; second accept at E34; hi_write pulsed during CALC leaves HI unchanged.
- MTHI 0xA5A5A5A5 in IDLE -> hi=0xA5A5A5A5 next cycle; then start MULTU and assert reset at E10 -> hi=lo=0, busy=0, and no done within the following 40 cycles.
